// File: rtl/frame_descrambler.sv
// Receive-side frame descrambler: hunts for the unscrambled sync word, confirms
// alignment through HUNT/PRESYNC/SYNC and descrambles payload words with an
// LFSR keystream that is reseeded at every frame boundary.
module frame_descrambler #(
    parameter logic [31:0] SYNC_WORD    = 32'hB6AB31E0,
    parameter int unsigned FRAME_WORDS  = 64,
    parameter int unsigned SYNC_CONFIRM = 2,
    parameter int unsigned LOSS_THRESH  = 3,
    parameter logic [15:0] SEED         = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    output logic        sof,
    output logic        locked,
    output logic        sync_loss
);

    localparam int unsigned CntW   = $clog2(FRAME_WORDS);
    localparam int unsigned MatchW = $clog2(SYNC_CONFIRM + 1);
    localparam int unsigned MissW  = $clog2(LOSS_THRESH + 1);

    localparam logic [CntW-1:0]   LastPos    = CntW'(FRAME_WORDS - 1);
    localparam logic [MatchW-1:0] ConfirmCnt = MatchW'(SYNC_CONFIRM);
    localparam logic [MissW-1:0]  LossCnt    = MissW'(LOSS_THRESH);

    typedef enum logic [1:0] {
        StHunt,
        StPresync,
        StSync
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [MatchW-1:0] match_cnt_q, match_cnt_d;
    logic [MissW-1:0]  miss_cnt_q, miss_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              data_out_valid_q, data_out_valid_d;
    logic              sof_q, sof_d;
    logic              locked_q, locked_d;
    logic              sync_loss_q, sync_loss_d;

    logic              match;
    logic              at_sync_slot;
    logic [CntW-1:0]   word_cnt_inc;
    logic [MatchW-1:0] match_inc;
    logic [MissW-1:0]  miss_inc;
    logic [15:0]       lfsr_step;
    logic [31:0]       keystream;

    assign match        = (data_in == SYNC_WORD);
    assign at_sync_slot = (word_cnt_q == '0);
    assign word_cnt_inc = (word_cnt_q == LastPos) ? '0 : word_cnt_q + 1'b1;
    assign match_inc    = match_cnt_q + 1'b1;
    assign miss_inc     = miss_cnt_q + 1'b1;
    assign lfsr_step    = {lfsr_q[7:0] ^ lfsr_q[15:8], lfsr_q[15:8]};

    // Keystream for the current payload word, taken from the present LFSR value.
    always_comb begin
        keystream = '0;
        for (int j = 0; j < 8; j++) begin
            keystream[j]      = lfsr_q[15-j];
            keystream[j + 8]  = lfsr_q[7-j] ^ lfsr_q[15-j];
            keystream[j + 16] = lfsr_q[7-j];
            keystream[j + 24] = lfsr_q[15-j];
        end
    end

    // Alignment FSM, LFSR control and next output values; invalid cycles hold all state.
    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        match_cnt_d      = match_cnt_q;
        miss_cnt_d       = miss_cnt_q;
        lfsr_d           = lfsr_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        sof_d            = 1'b0;
        sync_loss_d      = 1'b0;

        if (data_in_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (match) begin
                        state_d     = StPresync;
                        word_cnt_d  = CntW'(1);
                        match_cnt_d = MatchW'(1);
                        lfsr_d      = SEED;
                    end
                end
                StPresync: begin
                    if (at_sync_slot) begin
                        lfsr_d = SEED;
                        if (match) begin
                            word_cnt_d  = CntW'(1);
                            match_cnt_d = match_inc;
                            if (match_inc == ConfirmCnt) begin
                                state_d    = StSync;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            // The missed word is dropped, not searched again.
                            state_d     = StHunt;
                            word_cnt_d  = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end else begin
                        lfsr_d     = lfsr_step;
                        word_cnt_d = word_cnt_inc;
                    end
                end
                StSync: begin
                    if (at_sync_slot) begin
                        // Flywheel: reseed on the expected slot even if the sync word is bad.
                        lfsr_d     = SEED;
                        word_cnt_d = CntW'(1);
                        if (match) begin
                            miss_cnt_d = '0;
                        end else if (miss_inc == LossCnt) begin
                            state_d     = StHunt;
                            word_cnt_d  = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            sync_loss_d = 1'b1;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end else begin
                        data_out_d       = data_in ^ keystream;
                        data_out_valid_d = 1'b1;
                        sof_d            = (word_cnt_q == CntW'(1));
                        lfsr_d           = lfsr_step;
                        word_cnt_d       = word_cnt_inc;
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end

        locked_d = (state_d == StSync);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StHunt;
            word_cnt_q       <= '0;
            match_cnt_q      <= '0;
            miss_cnt_q       <= '0;
            lfsr_q           <= SEED;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            sof_q            <= 1'b0;
            locked_q         <= 1'b0;
            sync_loss_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_cnt_q       <= word_cnt_d;
            match_cnt_q      <= match_cnt_d;
            miss_cnt_q       <= miss_cnt_d;
            lfsr_q           <= lfsr_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            sof_q            <= sof_d;
            locked_q         <= locked_d;
            sync_loss_q      <= sync_loss_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign sof            = sof_q;
    assign locked         = locked_q;
    assign sync_loss      = sync_loss_q;

endmodule

// File: tb/tb_frame_descrambler.sv
// Bench for frame_descrambler: a transmit-side scrambler built from a precomputed
// keystream table drives frames, and a position-based receiver model predicts outputs.
module tb_frame_descrambler;

    localparam logic [31:0] SYNC    = 32'hB6AB31E0;
    localparam int          FW      = 64;
    localparam int          CONFIRM = 2;
    localparam int          THRESH  = 3;
    localparam logic [15:0] SEEDV   = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        sof;
    logic        locked;
    logic        sync_loss;

    frame_descrambler #(
        .SYNC_WORD   (SYNC),
        .FRAME_WORDS (FW),
        .SYNC_CONFIRM(CONFIRM),
        .LOSS_THRESH (THRESH),
        .SEED        (SEEDV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .sof           (sof),
        .locked        (locked),
        .sync_loss     (sync_loss)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int loss_pulses = 0;
    int dv_count    = 0;

    // Keystream per frame position (index 1..FW-1), built once from the scrambler rules.
    logic [31:0] ks [FW];

    // Receiver model: 0 = hunting, 1 = confirming, 2 = locked.
    int          mode, pos, hits, misses;
    logic [31:0] exp_dout;
    logic        exp_dv, exp_sof, exp_loss, exp_locked;

    bit          track = 1'b0;
    logic [31:0] pq [$];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] ks_of(input logic [15:0] q);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = q[15:8];
        lo = q[7:0];
        return {rev8(hi), rev8(lo), rev8(lo ^ hi), rev8(hi)};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = q >> 8;
        lo = q & 16'h00FF;
        return ((lo ^ hi) << 8) | hi;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; pos = 0; hits = 0; misses = 0;
        exp_dout = '0; exp_dv = 1'b0; exp_sof = 1'b0; exp_loss = 1'b0; exp_locked = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] w);
        exp_dv = 1'b0; exp_sof = 1'b0; exp_loss = 1'b0;
        if (v) begin
            case (mode)
                0: if (w == SYNC) begin mode = 1; pos = 1; hits = 1; end
                1: begin
                    if (pos == 0) begin
                        if (w == SYNC) begin
                            hits++;
                            pos = 1;
                            if (hits == CONFIRM) begin mode = 2; misses = 0; end
                        end else begin
                            mode = 0; pos = 0; hits = 0;
                        end
                    end else begin
                        pos = (pos + 1) % FW;
                    end
                end
                default: begin
                    if (pos == 0) begin
                        pos = 1;
                        if (w == SYNC) misses = 0;
                        else begin
                            misses++;
                            if (misses == THRESH) begin
                                mode = 0; pos = 0; hits = 0; misses = 0; exp_loss = 1'b1;
                            end
                        end
                    end else begin
                        exp_dv   = 1'b1;
                        exp_sof  = (pos == 1);
                        exp_dout = w ^ ks[pos];
                        pos      = (pos + 1) % FW;
                    end
                end
            endcase
        end
        exp_locked = (mode == 2);
    endtask

    task automatic apply(input logic [31:0] w, input logic v);
        logic [31:0] pexp;
        data_in       = w;
        data_in_valid = v;
        model_step(v, w);
        @(posedge clk);
        #1;
        vectors++;
        chk("data_out_valid", {31'd0, data_out_valid}, {31'd0, exp_dv});
        chk("sof", {31'd0, sof}, {31'd0, exp_sof});
        chk("locked", {31'd0, locked}, {31'd0, exp_locked});
        chk("sync_loss", {31'd0, sync_loss}, {31'd0, exp_loss});
        chk("data_out", data_out, exp_dout);
        if (sync_loss === 1'b1) loss_pulses++;
        if (data_out_valid === 1'b1) dv_count++;
        if (track && data_out_valid === 1'b1) begin
            if (pq.size() == 0) begin
                chk("plaintext_underrun", 32'd1, 32'd0);
            end else begin
                pexp = pq.pop_front();
                chk("plaintext", data_out, pexp);
            end
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        data_in_valid = 1'b0;
        #2;
        model_reset();
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_dv", {31'd0, data_out_valid}, 32'd0);
        chk("rst_sof", {31'd0, sof}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_sync_loss", {31'd0, sync_loss}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_payload(input int p, input bit zero_pl);
        logic [31:0] pl;
        pl = zero_pl ? 32'd0 : $urandom;
        if (track) pq.push_back(pl);
        apply(pl ^ ks[p], 1'b1);
    endtask

    task automatic send_frame(input bit good_sync, input bit zero_pl, input int gap_pct);
        for (int p = 0; p < FW; p++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) apply($urandom, 1'b0);
            if (p == 0) apply(good_sync ? SYNC : (SYNC ^ 32'h0000_0100), 1'b1);
            else send_payload(p, zero_pl);
        end
    endtask

    task automatic send_garbage(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == SYNC) w = ~w;
            apply(w, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] q;
        q = SEEDV;
        ks[0] = '0;
        for (int p = 1; p < FW; p++) begin
            ks[p] = ks_of(q);
            q     = lfsr_next(q);
        end
        model_reset();

        #1;
        do_reset();

        // Keystream: all-zero payload, first payload word of frame 2 is the known constant.
        send_frame(1'b1, 1'b1, 0);
        apply(SYNC, 1'b1);
        apply(32'h7BB5CE7B, 1'b1);
        chk("ks_word1_out", data_out, 32'h0000_0000);
        chk("ks_word1_sof", {31'd0, sof}, 32'd1);
        chk("ks_word1_locked", {31'd0, locked}, 32'd1);
        for (int p = 2; p < FW; p++) send_payload(p, 1'b1);
        send_frame(1'b1, 1'b1, 0);

        // Lock acquisition after random leading garbage.
        do_reset();
        send_garbage(17 + $urandom_range(30));
        dv_count = 0;
        send_frame(1'b1, 1'b0, 0);
        chk("acq_no_output_frame1", dv_count, 32'd0);
        send_frame(1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        chk("acq_output_count", dv_count, 32'(2 * (FW - 1)));

        // False lock: a lone sync word with no sync one frame later.
        do_reset();
        dv_count = 0;
        apply(SYNC, 1'b1);
        send_garbage(FW - 1);
        send_garbage(FW + 5);
        chk("false_lock_locked", {31'd0, locked}, 32'd0);
        chk("false_lock_dv", dv_count, 32'd0);

        // Flywheel: two bad sync words are tolerated, three drop lock.
        do_reset();
        send_frame(1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        loss_pulses = 0;
        send_frame(1'b0, 1'b0, 0);
        send_frame(1'b0, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        chk("fly_locked", {31'd0, locked}, 32'd1);
        send_frame(1'b0, 1'b0, 0);
        send_frame(1'b0, 1'b0, 0);
        send_frame(1'b0, 1'b0, 0);
        chk("fly_loss_pulses", loss_pulses, 32'd1);
        chk("fly_unlocked", {31'd0, locked}, 32'd0);

        // Valid gaps: plaintext must come out unchanged despite random stalls.
        do_reset();
        send_frame(1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        track = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(1'b1, 1'b0, 50);
        track = 1'b0;
        chk("gap_queue_drained", pq.size(), 32'd0);
        pq.delete();

        // Asynchronous reset mid-frame while locked, then relock.
        do_reset();
        send_frame(1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        apply(SYNC, 1'b1);
        for (int p = 1; p <= 20; p++) send_payload(p, 1'b0);
        do_reset();
        for (int p = 21; p < FW; p++) send_payload(p, 1'b0);
        chk("rst_mid_unlocked", {31'd0, locked}, 32'd0);
        send_frame(1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        send_frame(1'b1, 1'b0, 0);
        chk("relock_locked", {31'd0, locked}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
